// File: rtl/riscv_bus_arbiter.sv
// Two-port (instruction fetch / data) arbiter onto one shared memory bus.
// Optional macro ARBITER_ROUND_ROBIN_EN: alternate priority on simultaneous requests.
module riscv_bus_arbiter (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] i_address,
  input  logic        i_read,
  output logic [31:0] i_data,
  output logic        i_ready,
  input  logic [31:0] d_address,
  input  logic [1:0]  d_width,
  input  logic [31:0] d_wdata,
  input  logic        d_read,
  input  logic        d_write,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic [31:0] m_address,
  output logic [1:0]  m_width,
  output logic [31:0] m_wdata,
  output logic        m_read,
  output logic        m_write,
  input  logic [31:0] m_rdata,
  input  logic        m_ready,
  output logic [1:0]  owner
);

  // The state encoding doubles as the owner code: IDLE=0, INSTR=1, DATA=2.
  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_INSTR = 2'd1,
    OWN_DATA  = 2'd2
  } owner_e;

  owner_e state_q, state_d;
  owner_e grant;
  logic   d_req;
  logic   data_first;

  assign d_req = d_read | d_write;

`ifdef ARBITER_ROUND_ROBIN_EN
  logic last_data_q, last_data_d;

  assign data_first = ~last_data_q;

  always_comb begin
    last_data_d = last_data_q;
    if (grant != OWN_NONE && m_ready) last_data_d = (grant == OWN_DATA);
  end

  always_ff @(posedge clock) begin
    if (reset) last_data_q <= 1'b0;
    else       last_data_q <= last_data_d;
  end
`else
  assign data_first = 1'b1;
`endif

  // A locked owner keeps the bus until m_ready or until it withdraws;
  // only IDLE looks at the other port.
  always_comb begin
    // NOTE: default assigned first so no path through this block infers a latch.
    grant = OWN_NONE;
    if (!reset) begin
      case (state_q)
        OWN_INSTR: grant = i_read ? OWN_INSTR : OWN_NONE;
        OWN_DATA:  grant = d_req  ? OWN_DATA  : OWN_NONE;
        default: begin
          if (i_read && d_req) grant = data_first ? OWN_DATA : OWN_INSTR;
          else if (d_req)      grant = OWN_DATA;
          else if (i_read)     grant = OWN_INSTR;
        end
      endcase
    end
  end

  always_comb begin
    state_d = OWN_NONE;
    if (grant != OWN_NONE && !m_ready) state_d = grant;
  end

  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignment for every registered value.
    if (reset) state_q <= OWN_NONE;
    else       state_q <= state_d;
  end

  always_comb begin
    m_address = 32'd0;
    m_width   = 2'd0;
    m_wdata   = 32'd0;
    m_read    = 1'b0;
    m_write   = 1'b0;
    i_ready   = 1'b0;
    d_ready   = 1'b0;
    case (grant)
      OWN_INSTR: begin
        m_address = i_address;
        m_width   = 2'd2;
        m_read    = 1'b1;
        i_ready   = m_ready;
      end
      OWN_DATA: begin
        m_address = d_address;
        m_width   = d_width;
        m_wdata   = d_wdata;
        m_read    = d_read;
        m_write   = d_write;
        d_ready   = m_ready;
      end
      default: ;
    endcase
  end

  assign owner   = grant;
  assign i_data  = m_rdata;
  assign d_rdata = m_rdata;

endmodule
